fb_write_scheduler: RTL and testbench

Sequencing and arbitration stage in front of the frame buffer's single GPU-side write port. Two pixel requesters share the port under round-robin arbitration. A built-in clear sequencer can fill the whole visible frame with one colour. Outputs drive the frame buffer top's `gpu_x`, `gpu_y`, `gpu_data` and `gpu_we` inputs directly, in the GPU clock domain.

---
 rtl/fb_pkg.sv | 30 +++
 rtl/fb_clear_sequencer.sv | 63 ++++++
 rtl/fb_write_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_fb_write_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer write path.
//   FB_COORD_W / FB_PIXEL_W : coordinate and pixel widths
//   FB_H_RES / FB_V_RES     : default visible resolution
//   FB_DROP_W               : width of the dropped-request counter
//   fb_sched_state_t        : write scheduler FSM states
//   fb_in_range()           : visible-area test for a coordinate pair
package fb_pkg;

    localparam int FB_COORD_W = 10;
    localparam int FB_PIXEL_W = 4;
    localparam int FB_H_RES   = 320;
    localparam int FB_V_RES   = 240;
    localparam int FB_DROP_W  = 16;

    typedef enum logic {
        FB_ARB   = 1'b0,
        FB_CLEAR = 1'b1
    } fb_sched_state_t;

    // True when (x, y) lies inside an h_res x v_res visible area.
    function automatic logic fb_in_range(
        input logic [FB_COORD_W-1:0] x,
        input logic [FB_COORD_W-1:0] y,
        input int                    h_res,
        input int                    v_res
    );
        return (int'(x) < h_res) && (int'(y) < v_res);
    endfunction

endpackage

// File: rtl/fb_clear_sequencer.sv
// Raster counter used by the frame clear: walks (cx, cy) across the
// visible area, column first, one position per advance.
//   clk, srst : clock and synchronous active-high reset
//   start     : restart the raster at (0, 0)
//   advance   : step to the next pixel position
//   cx, cy    : current raster position
//   last      : current position is (H_RES-1, V_RES-1)
module fb_clear_sequencer
    import fb_pkg::*;
#(
    parameter int H_RES = FB_H_RES,
    parameter int V_RES = FB_V_RES
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  start,
    input  logic                  advance,
    output logic [FB_COORD_W-1:0] cx,
    output logic [FB_COORD_W-1:0] cy,
    output logic                  last
);

    localparam logic [FB_COORD_W-1:0] CX_MAX = FB_COORD_W'(H_RES - 1);
    localparam logic [FB_COORD_W-1:0] CY_MAX = FB_COORD_W'(V_RES - 1);

    logic [FB_COORD_W-1:0] cx_reg, cx_next;
    logic [FB_COORD_W-1:0] cy_reg, cy_next;
    logic                  cx_wrap;

    assign cx_wrap = (cx_reg == CX_MAX);
    assign last    = cx_wrap && (cy_reg == CY_MAX);
    assign cx      = cx_reg;
    assign cy      = cy_reg;

    always_comb begin
        cx_next = cx_reg;
        cy_next = cy_reg;
        if (start) begin
            cx_next = '0;
            cy_next = '0;
        end else if (advance) begin
            if (cx_wrap) begin
                cx_next = '0;
                // Wrapping to (0,0) after the final pixel leaves the
                // counter ready for the next clear without a restart.
                cy_next = last ? '0 : cy_reg + 1'b1;
            end else begin
                cx_next = cx_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cx_reg <= '0;
            cy_reg <= '0;
        end else begin
            cx_reg <= cx_next;
            cy_reg <= cy_next;
        end
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// Arbitrates two pixel requesters onto the frame buffer's single write
// port (round robin) and runs a whole-frame clear on request.
//   Clk, Reset            : clock and synchronous active-high reset
//   clear_req/clear_color : start a clear with the given fill value
//   clear_busy            : clear in progress
//   reqN_valid/x/y/data   : pixel write request from requester N
//   reqN_ready            : requester N accepted this cycle
//   fb_x/fb_y/fb_data/fb_we : registered write port to the frame buffer
//   drop_count            : saturating count of out-of-range requests
module fb_write_scheduler
    import fb_pkg::*;
#(
    parameter int H_RES = FB_H_RES,
    parameter int V_RES = FB_V_RES
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  clear_req,
    input  logic [FB_PIXEL_W-1:0] clear_color,
    output logic                  clear_busy,
    input  logic                  req0_valid,
    input  logic [FB_COORD_W-1:0] req0_x,
    input  logic [FB_COORD_W-1:0] req0_y,
    input  logic [FB_PIXEL_W-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [FB_COORD_W-1:0] req1_x,
    input  logic [FB_COORD_W-1:0] req1_y,
    input  logic [FB_PIXEL_W-1:0] req1_data,
    output logic                  req1_ready,
    output logic [FB_COORD_W-1:0] fb_x,
    output logic [FB_COORD_W-1:0] fb_y,
    output logic [FB_PIXEL_W-1:0] fb_data,
    output logic                  fb_we,
    output logic [FB_DROP_W-1:0]  drop_count
);

    fb_sched_state_t state_reg, state_next;

    logic                  last_grant_reg;
    logic [FB_PIXEL_W-1:0] clear_color_reg;
    logic [FB_COORD_W-1:0] fb_x_reg, fb_y_reg;
    logic [FB_PIXEL_W-1:0] fb_data_reg;
    logic                  fb_we_reg;
    logic [FB_DROP_W-1:0]  drop_count_reg;

    logic [1:0] req_valid;
    logic [1:0] ready_vec;
    logic       grant;
    logic       arb_open;
    logic       xfer;

    logic [FB_COORD_W-1:0] sel_x, sel_y;
    logic [FB_PIXEL_W-1:0] sel_data;
    logic                  sel_in_range;

    logic                  seq_start, seq_advance, seq_last;
    logic [FB_COORD_W-1:0] seq_cx, seq_cy;

    assign req_valid = {req1_valid, req0_valid};

    // ---------------- clear raster counter ----------------
    fb_clear_sequencer #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_clear_seq (
        .clk     (Clk),
        .srst    (Reset),
        .start   (seq_start),
        .advance (seq_advance),
        .cx      (seq_cx),
        .cy      (seq_cy),
        .last    (seq_last)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= FB_ARB;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FB_ARB:   if (clear_req) state_next = FB_CLEAR;
            FB_CLEAR: if (seq_last)  state_next = FB_ARB;
            default:  state_next = FB_ARB;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        arb_open    = 1'b0;
        clear_busy  = 1'b0;
        seq_start   = 1'b0;
        seq_advance = 1'b0;
        case (state_reg)
            FB_ARB: begin
                // A clear request takes the cycle away from requesters.
                arb_open  = !clear_req && !Reset;
                seq_start = clear_req;
            end
            FB_CLEAR: begin
                clear_busy  = 1'b1;
                seq_advance = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- round-robin grant ----------------
    // With both valid the requester that did not win last time gets the
    // port; with one valid that one wins regardless of history.
    always_comb begin
        if (req_valid == 2'b11) begin
            grant = ~last_grant_reg;
        end else begin
            grant = req_valid[1];
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = arb_open && req_valid[gi] && (grant == 1'(gi));
        end
    endgenerate

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];
    assign xfer       = |ready_vec;

    assign sel_x        = grant ? req1_x    : req0_x;
    assign sel_y        = grant ? req1_y    : req0_y;
    assign sel_data     = grant ? req1_data : req0_data;
    assign sel_in_range = fb_in_range(sel_x, sel_y, H_RES, V_RES);

    // ---------------- grant history and clear colour ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            // Starting at 1 lets req0 win the first contention.
            last_grant_reg  <= 1'b1;
            clear_color_reg <= '0;
        end else begin
            if (xfer) begin
                last_grant_reg <= grant;
            end
            if (seq_start) begin
                clear_color_reg <= clear_color;
            end
        end
    end

    // ---------------- write port register ----------------
    // Address and data only move on an actual write, so they hold their
    // last value across idle cycles and dropped requests.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fb_x_reg    <= '0;
            fb_y_reg    <= '0;
            fb_data_reg <= '0;
            fb_we_reg   <= 1'b0;
        end else if (state_reg == FB_CLEAR) begin
            fb_x_reg    <= seq_cx;
            fb_y_reg    <= seq_cy;
            fb_data_reg <= clear_color_reg;
            fb_we_reg   <= 1'b1;
        end else if (xfer && sel_in_range) begin
            fb_x_reg    <= sel_x;
            fb_y_reg    <= sel_y;
            fb_data_reg <= sel_data;
            fb_we_reg   <= 1'b1;
        end else begin
            fb_we_reg   <= 1'b0;
        end
    end

    // ---------------- dropped-request counter ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            drop_count_reg <= '0;
        end else if (xfer && !sel_in_range && (drop_count_reg != '1)) begin
            drop_count_reg <= drop_count_reg + 1'b1;
        end
    end

    assign fb_x       = fb_x_reg;
    assign fb_y       = fb_y_reg;
    assign fb_data    = fb_data_reg;
    assign fb_we      = fb_we_reg;
    assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler at default 320x240 resolution.
module tb_fb_write_scheduler;
    import fb_pkg::*;

    logic                  Clk = 1'b0;
    logic                  Reset;
    logic                  clear_req;
    logic [FB_PIXEL_W-1:0] clear_color;
    logic                  clear_busy;
    logic                  req0_valid, req1_valid;
    logic [FB_COORD_W-1:0] req0_x, req0_y, req1_x, req1_y;
    logic [FB_PIXEL_W-1:0] req0_data, req1_data;
    logic                  req0_ready, req1_ready;
    logic [FB_COORD_W-1:0] fb_x, fb_y;
    logic [FB_PIXEL_W-1:0] fb_data;
    logic                  fb_we;
    logic [FB_DROP_W-1:0]  drop_count;

    int checks = 0;
    int errors = 0;

    fb_write_scheduler dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .req0_valid  (req0_valid),
        .req0_x      (req0_x),
        .req0_y      (req0_y),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_x      (req1_x),
        .req1_y      (req1_y),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .fb_x        (fb_x),
        .fb_y        (fb_y),
        .fb_data     (fb_data),
        .fb_we       (fb_we),
        .drop_count  (drop_count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Registered outputs are read 1 time unit after the rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        int pix_errs;
        int p;
        logic exp_g;

        Reset = 1'b1; clear_req = 1'b0; clear_color = '0;
        req0_valid = 1'b1; req0_x = 10'd1; req0_y = 10'd1; req0_data = 4'h3;
        req1_valid = 1'b1; req1_x = 10'd2; req1_y = 10'd2; req1_data = 4'h5;

        // ---------------- reset values ----------------
        step(); step();
        chk("rst_fb_x", fb_x, 0);
        chk("rst_fb_y", fb_y, 0);
        chk("rst_fb_data", fb_data, 0);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_busy", clear_busy, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);

        // ---------------- contention: grants alternate 0,1,0,1 ----------------
        Reset = 1'b0;
        settle();
        for (int i = 0; i < 6; i++) begin
            exp_g = 1'(i % 2);
            chk($sformatf("cont_ready0_%0d", i), req0_ready, !exp_g);
            chk($sformatf("cont_ready1_%0d", i), req1_ready, exp_g);
            step();
            chk($sformatf("cont_we_%0d", i), fb_we, 1);
            chk($sformatf("cont_x_%0d", i), fb_x, exp_g ? 2 : 1);
            chk($sformatf("cont_data_%0d", i), fb_data, exp_g ? 4'h5 : 4'h3);
            settle();
        end

        // ---------------- out of range ----------------
        req1_valid = 1'b0;
        req0_x = 10'd320; req0_y = 10'd0; req0_data = 4'h7;
        settle();
        chk("oor_x_ready0", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        chk("oor_x_we", fb_we, 0);
        chk("oor_x_drop", drop_count, 1);
        chk("oor_x_hold_x", fb_x, 2);
        req0_valid = 1'b1; req0_x = 10'd5; req0_y = 10'd240;
        settle();
        chk("oor_y_ready0", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        chk("oor_y_we", fb_we, 0);
        chk("oor_y_drop", drop_count, 2);

        // Saturation: preload the counter at its ceiling.
        force dut.drop_count_reg = 16'hFFFF;
        settle();
        release dut.drop_count_reg;
        req0_valid = 1'b1; req0_x = 10'd400; req0_y = 10'd0;
        settle();
        chk("sat_ready0", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        chk("sat_drop", drop_count, 16'hFFFF);
        chk("sat_we", fb_we, 0);

        // ---------------- reset mid-traffic ----------------
        req0_valid = 1'b1; req0_x = 10'd1; req0_y = 10'd1; req0_data = 4'h3;
        req1_valid = 1'b1;
        step();
        Reset = 1'b1;
        settle();
        chk("mrst_ready0", req0_ready, 0);
        chk("mrst_ready1", req1_ready, 0);
        step(); step();
        chk("mrst_we", fb_we, 0);
        chk("mrst_x", fb_x, 0);
        chk("mrst_data", fb_data, 0);
        chk("mrst_drop", drop_count, 0);
        chk("mrst_busy", clear_busy, 0);
        Reset = 1'b0;
        settle();
        chk("mrst_first_ready0", req0_ready, 1);
        chk("mrst_first_ready1", req1_ready, 0);
        step();
        chk("mrst_first_x", fb_x, 1);

        // ---------------- single requester, twice in a row ----------------
        req0_valid = 1'b0;
        settle();
        chk("single1_ready_a", req1_ready, 1);
        step();
        chk("single1_ready_b", req1_ready, 1);
        step();
        chk("single1_x", fb_x, 2);
        chk("single1_we", fb_we, 1);

        // ---------------- clear sweep with priority over req1 ----------------
        clear_req = 1'b1; clear_color = 4'hA;
        settle();
        chk("clrpri_ready1", req1_ready, 0);
        chk("clrpri_ready0", req0_ready, 0);
        chk("clrpri_busy", clear_busy, 0);
        step();                         // cycle N sampled; now in N+1
        clear_req = 1'b0; clear_color = 4'h0;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_x = 10'd7; req0_y = 10'd8; req0_data = 4'h1;
        pix_errs = 0;
        for (int i = 1; i <= 76800; i++) begin
            clear_req = (i == 500);     // a second request must be ignored
            settle();
            if (i == 1) begin
                chk("clr_n1_busy", clear_busy, 1);
                chk("clr_n1_we", fb_we, 0);
            end
            if (i == 2) begin
                chk("clr_first_we", fb_we, 1);
                chk("clr_first_x", fb_x, 0);
                chk("clr_first_y", fb_y, 0);
                chk("clr_first_data", fb_data, 4'hA);
            end
            if (clear_busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
                pix_errs++;
            if (i >= 2) begin
                p = i - 2;
                if (fb_we !== 1'b1 || fb_data !== 4'hA ||
                    fb_x !== 10'(p % 320) || fb_y !== 10'(p / 320))
                    pix_errs++;
            end
            step();
        end
        clear_req = 1'b0;
        settle();
        chk("clr_sweep_errs", pix_errs, 0);
        chk("clr_end_busy", clear_busy, 0);
        chk("clr_end_ready0", req0_ready, 1);
        chk("clr_last_we", fb_we, 1);
        chk("clr_last_x", fb_x, 319);
        chk("clr_last_y", fb_y, 239);
        chk("clr_last_data", fb_data, 4'hA);
        step();
        req0_valid = 1'b0;
        chk("post_clr_we", fb_we, 1);
        chk("post_clr_x", fb_x, 7);
        chk("post_clr_y", fb_y, 8);
        chk("post_clr_data", fb_data, 4'h1);

        // ---------------- reset mid-clear ----------------
        clear_req = 1'b1; clear_color = 4'hC;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 1000; i++) step();
        // Clear pixel 1000 is being issued; pixel 999 is on the port.
        chk("mclr_x", fb_x, 39);
        chk("mclr_y", fb_y, 3);
        chk("mclr_busy", clear_busy, 1);
        Reset = 1'b1;
        step();
        chk("mclr_rst_we", fb_we, 0);
        chk("mclr_rst_busy", clear_busy, 0);
        Reset = 1'b0;
        step();
        chk("mclr_after_we", fb_we, 0);
        chk("mclr_after_busy", clear_busy, 0);
        req0_valid = 1'b1; req0_x = 10'd5; req0_y = 10'd6; req0_data = 4'hC;
        settle();
        chk("mclr_req_ready0", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        chk("mclr_req_we", fb_we, 1);
        chk("mclr_req_x", fb_x, 5);
        chk("mclr_req_y", fb_y, 6);
        step();
        chk("mclr_idle_we", fb_we, 0);
        chk("mclr_idle_hold_x", fb_x, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
